cpu_bus_arbiter: RTL and testbench

//  Owns the CPU memory bus and shares it between three masters: CPU (default), sys_ctrl debug port, OAM DMA.
//  Non-CPU requests halt the CPU, wait for cpu_is_halted, then grant the bus to one master until it releases.

---
 rtl/cpu_bus_arbiter_pkg.sv | 23 ++
 rtl/cpu_bus_arbiter_bus_halt_timer.sv | 32 +++
 rtl/cpu_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared encodings for the CPU bus arbiter: bus owner codes and FSM states.
// Also holds a helper that names the other non-CPU master.
package cpu_bus_arbiter_pkg;

  localparam logic [1:0] OWN_CPU = 2'd0;
  localparam logic [1:0] OWN_DBG = 2'd1;
  localparam logic [1:0] OWN_DMA = 2'd2;

  typedef enum logic [2:0] {
    ST_CPU_OWN   = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_GNT_DBG   = 3'd2,
    ST_GNT_DMA   = 3'd3,
    ST_HANDOFF   = 3'd4,
    ST_RELEASE   = 3'd5
  } arb_state_e;

  // The master that could be waiting while the given one holds the bus.
  function automatic logic [1:0] other_master(input logic [1:0] own);
    return (own == OWN_DBG) ? OWN_DMA : OWN_DBG;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_bus_halt_timer.sv
// 8-bit saturating halt-acknowledge timer with a registered one-shot expiry pulse.
module bus_halt_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_r;
  logic       expired_r;

  // Count while enabled, hold at LIMIT; the pulse fires on the step that reaches LIMIT.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_r   <= 8'd0;
      expired_r <= 1'b0;
    end else if (enable) begin
      if (count_r != LIMIT) begin
        count_r <= count_r + 8'd1;
      end
      expired_r <= (count_r == (LIMIT - 8'd1));
    end else begin
      expired_r <= 1'b0;
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/cpu_bus_arbiter.sv
// CPU memory bus arbiter: halts the CPU on debug/DMA requests, grants the bus to one
// master at a time and muxes the memory-side bus from the registered owner.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter logic [7:0] HALT_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic        cpu_halt,
  input  logic        cpu_is_halted,
  input  logic        dbg_req,
  output logic        dbg_gnt,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  input  logic        dbg_we,
  input  logic        dbg_re,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  input  logic        dma_re,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [1:0]  owner,
  output logic        halt_timeout
);

  arb_state_e state_r;
  logic       cpu_halt_r;
  logic       dbg_gnt_r;
  logic       dma_gnt_r;
  logic [1:0] owner_r;
  logic       waiting_s;
  logic       dead_s;
  logic       timeout_s;

  assign waiting_s = (state_r == ST_HALT_WAIT);
  assign dead_s    = (state_r == ST_HANDOFF) || (state_r == ST_RELEASE);

  bus_halt_timer #(
    .LIMIT (HALT_TIMEOUT)
  ) u_halt_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting_s),
    .enable  (waiting_s),
    .expired (timeout_s)
  );

  // Arbitration FSM; grants and owner are registered so they appear the cycle after the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_CPU_OWN;
      cpu_halt_r <= 1'b0;
      dbg_gnt_r  <= 1'b0;
      dma_gnt_r  <= 1'b0;
      owner_r    <= OWN_CPU;
    end else begin
      case (state_r)
        ST_CPU_OWN: begin
          if (dbg_req || dma_req) begin
            cpu_halt_r <= 1'b1;
            state_r    <= ST_HALT_WAIT;
          end
        end
        ST_HALT_WAIT: begin
          if (!dbg_req && !dma_req) begin
            state_r <= ST_RELEASE;
          end else if (cpu_is_halted) begin
            if (dbg_req) begin
              dbg_gnt_r <= 1'b1;
              owner_r   <= OWN_DBG;
              state_r   <= ST_GNT_DBG;
            end else begin
              dma_gnt_r <= 1'b1;
              owner_r   <= OWN_DMA;
              state_r   <= ST_GNT_DMA;
            end
          end
        end
        ST_GNT_DBG: begin
          if (!dbg_req) begin
            dbg_gnt_r <= 1'b0;
            state_r   <= dma_req ? ST_HANDOFF : ST_RELEASE;
          end
        end
        ST_GNT_DMA: begin
          if (!dma_req) begin
            dma_gnt_r <= 1'b0;
            state_r   <= dbg_req ? ST_HANDOFF : ST_RELEASE;
          end
        end
        ST_HANDOFF: begin
          // The waiting master is whichever one did not just own the bus.
          if (other_master(owner_r) == OWN_DMA) begin
            if (dma_req) begin
              dma_gnt_r <= 1'b1;
              owner_r   <= OWN_DMA;
              state_r   <= ST_GNT_DMA;
            end else begin
              state_r <= ST_RELEASE;
            end
          end else begin
            if (dbg_req) begin
              dbg_gnt_r <= 1'b1;
              owner_r   <= OWN_DBG;
              state_r   <= ST_GNT_DBG;
            end else begin
              state_r <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          cpu_halt_r <= 1'b0;
          owner_r    <= OWN_CPU;
          state_r    <= ST_CPU_OWN;
        end
        default: begin
          state_r    <= ST_CPU_OWN;
          cpu_halt_r <= 1'b0;
          dbg_gnt_r  <= 1'b0;
          dma_gnt_r  <= 1'b0;
          owner_r    <= OWN_CPU;
        end
      endcase
    end
  end

  // Memory-side mux driven by the registered owner; strobes gated during dead cycles.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (owner_r)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we && !dead_s;
        mem_re    = cpu_re && !dead_s;
      end
      OWN_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_we && dbg_gnt_r && !dead_s;
        mem_re    = dbg_re && dbg_gnt_r && !dead_s;
      end
      OWN_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we && dma_gnt_r && !dead_s;
        mem_re    = dma_re && dma_gnt_r && !dead_s;
      end
      default: begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
      end
    endcase
  end

  assign cpu_halt     = cpu_halt_r;
  assign dbg_gnt      = dbg_gnt_r;
  assign dma_gnt      = dma_gnt_r;
  assign owner        = owner_r;
  assign halt_timeout = timeout_s;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: each step queues the expected bus view
// and it is popped and compared once the DUT has clocked.
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, dbg_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dbg_wdata, dma_wdata, mem_wdata;
  logic        cpu_we, cpu_re, dbg_we, dbg_re, dma_we, dma_re, mem_we, mem_re;
  logic        cpu_halt, cpu_is_halted, dbg_req, dbg_gnt, dma_req, dma_gnt, halt_timeout;
  logic [1:0]  owner;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(
    .HALT_TIMEOUT (8'd8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_we        (cpu_we),
    .cpu_re        (cpu_re),
    .cpu_halt      (cpu_halt),
    .cpu_is_halted (cpu_is_halted),
    .dbg_req       (dbg_req),
    .dbg_gnt       (dbg_gnt),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_we        (dbg_we),
    .dbg_re        (dbg_re),
    .dma_req       (dma_req),
    .dma_gnt       (dma_gnt),
    .dma_addr      (dma_addr),
    .dma_wdata     (dma_wdata),
    .dma_we        (dma_we),
    .dma_re        (dma_re),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .owner         (owner),
    .halt_timeout  (halt_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (halt,dg,mg,own,to,we,re|addr|data)", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bus_of(input logic [1:0] own);
    case (own)
      2'd0:    return {cpu_addr, cpu_wdata};
      2'd1:    return {dbg_addr, dbg_wdata};
      2'd2:    return {dma_addr, dma_wdata};
      default: return 24'h000000;
    endcase
  endfunction

  task automatic sb_drain();
    logic [31:0] obs;
    sb_t e;
    obs = {cpu_halt, dbg_gnt, dma_gnt, owner, halt_timeout, mem_we, mem_re, mem_addr, mem_wdata};
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  // Inputs are already set; queue the expectation, clock once, compare away from the edge.
  task automatic step(input string tag, input logic h, input logic dg, input logic mg,
                      input logic [1:0] own, input logic to, input logic we, input logic re);
    sb_t e;
    e.tag = tag;
    e.exp = {h, dg, mg, own, to, we, re, bus_of(own)};
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    sb_drain();
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = 16'hC0DE; cpu_wdata = 8'h3C; cpu_we = 1'b0; cpu_re = 1'b1;
    dbg_addr = 16'h0200; dbg_wdata = 8'hA5; dbg_we = 1'b0; dbg_re = 1'b0;
    dma_addr = 16'hFE00; dma_wdata = 8'h5A; dma_we = 1'b0; dma_re = 1'b1;
    cpu_is_halted = 1'b0; dbg_req = 1'b0; dma_req = 1'b0;

    step("reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    step("idle", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Debug request, CPU acks after 3 cycles, debug writes 0x0200 <= 0xA5.
    cpu_we = 1'b1; cpu_re = 1'b0; dbg_req = 1'b1;
    step("dbg_halt", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step("dbg_wait2", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step("dbg_wait3", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    cpu_is_halted = 1'b1; dbg_we = 1'b1;
    step("dbg_gnt", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    step("dbg_hold", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    dbg_we = 1'b0; dbg_req = 1'b0;
    step("dbg_release", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    cpu_is_halted = 1'b0;
    step("dbg_cpu_back", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Simultaneous requests: debug wins, then hand off to DMA, then reset mid-grant.
    dbg_req = 1'b1; dma_req = 1'b1; cpu_is_halted = 1'b1;
    step("both_halt", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step("both_dbg_first", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    dbg_req = 1'b0;
    step("handoff", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step("dma_gnt", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    step("dma_hold", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    step("rst_mid_grant", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; dma_req = 1'b0; cpu_is_halted = 1'b0;
    step("after_rst", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Halt never acked: timeout pulses once on the 8th waiting cycle, a late ack still grants.
    dma_req = 1'b1;
    step("to_enter", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("to_wait%0d", i), 1'b1, 1'b0, 1'b0, 2'd0, (i == 8), 1'b0, 1'b0);
    end
    cpu_is_halted = 1'b1;
    step("to_late_gnt", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    dma_req = 1'b0; cpu_is_halted = 1'b0;
    step("to_release", 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    step("to_cpu_back", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // DMA withdraws before ack: release with CPU strobes blanked, no grant.
    cpu_we = 1'b1; dma_req = 1'b1;
    step("wd_halt", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    dma_req = 1'b0;
    step("wd_release", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("wd_cpu_back", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Handoff target drops its request, then a request rising in RELEASE waits for CPU_OWN.
    dbg_req = 1'b1; dma_req = 1'b1; cpu_is_halted = 1'b1;
    step("hd_halt", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step("hd_dbg", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    dbg_req = 1'b0;
    step("hd_handoff", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    dma_req = 1'b0;
    step("hd_release", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    dma_req = 1'b1;
    step("rel_no_shortcut", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step("rel_rehalt", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step("rel_dma_gnt", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
